// File: rtl/sdram_port_arbiter.sv
// Two-master arbiter in front of the SDRAM controller inport, with an in-order tag FIFO for ack routing.
// Define SDRAM_ARB_RR_EN for round-robin tie-break; otherwise m0 wins ties (fixed priority).
module sdram_port_arbiter #(
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  m0_wr_i,
  input  logic        m0_rd_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_write_data_i,
  output logic        m0_accept_o,
  output logic        m0_ack_o,
  output logic [31:0] m0_read_data_o,
  input  logic [3:0]  m1_wr_i,
  input  logic        m1_rd_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_write_data_i,
  output logic        m1_accept_o,
  output logic        m1_ack_o,
  output logic [31:0] m1_read_data_o,
  output logic [3:0]  inport_wr_o,
  output logic        inport_rd_o,
  output logic [31:0] inport_addr_o,
  output logic [31:0] inport_write_data_o,
  input  logic        inport_accept_i,
  input  logic        inport_ack_i,
  input  logic [31:0] inport_read_data_i,
  output logic        err_o
);

  localparam int unsigned CW = $clog2(OUTSTANDING + 1);
  localparam int unsigned PW = $clog2(OUTSTANDING);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic [OUTSTANDING-1:0] tags_q, tags_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   err_q, err_d;
`ifdef SDRAM_ARB_RR_EN
  logic                   last_q, last_d;
`endif

  logic req0, req1, winner, win_valid, full, empty, fwd, accept, pop, head;

  assign req0  = m0_rd_i | (|m0_wr_i);
  assign req1  = m1_rd_i | (|m1_wr_i);
  assign full  = (count_q == CW'(OUTSTANDING));
  assign empty = (count_q == '0);
  assign head  = tags_q[rd_ptr_q];

  always_comb begin
    winner    = 1'b0;
    win_valid = 1'b0;
    if (state_q == LOCKED) begin
      winner    = owner_q;
      win_valid = owner_q ? req1 : req0;
    end else if (req0 && req1) begin
`ifdef SDRAM_ARB_RR_EN
      winner = ~last_q;
`else
      winner = 1'b0;
`endif
      win_valid = 1'b1;
    end else if (req1) begin
      winner    = 1'b1;
      win_valid = 1'b1;
    end else if (req0) begin
      win_valid = 1'b1;
    end
  end

  // Gating with rst_i keeps inport quiet for the whole asynchronous reset pulse.
  assign fwd    = win_valid & ~full & ~rst_i;
  assign accept = inport_accept_i & fwd;
  assign pop    = inport_ack_i & ~empty;

  always_comb begin
    inport_rd_o         = 1'b0;
    inport_wr_o         = '0;
    inport_addr_o       = '0;
    inport_write_data_o = '0;
    if (fwd) begin
      if (winner) begin
        inport_rd_o         = m1_rd_i;
        inport_wr_o         = m1_wr_i;
        inport_addr_o       = m1_addr_i;
        inport_write_data_o = m1_write_data_i;
      end else begin
        inport_rd_o         = m0_rd_i;
        inport_wr_o         = m0_wr_i;
        inport_addr_o       = m0_addr_i;
        inport_write_data_o = m0_write_data_i;
      end
    end
  end

  assign m0_accept_o    = accept & ~winner;
  assign m1_accept_o    = accept & winner;
  assign m0_ack_o       = pop & ~head;
  assign m1_ack_o       = pop & head;
  assign m0_read_data_o = inport_read_data_i;
  assign m1_read_data_o = inport_read_data_i;
  assign err_o          = err_q;

  // While full nothing is forwarded, so the lock state simply holds.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      UNLOCKED: begin
        if (fwd && !inport_accept_i) begin
          state_d = LOCKED;
          owner_d = winner;
        end
      end
      LOCKED: begin
        if (accept) state_d = UNLOCKED;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_comb begin
    tags_d = tags_q;
    if (accept) tags_d[wr_ptr_q] = winner;
    wr_ptr_d = wr_ptr_q + PW'(accept);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(accept) - CW'(pop);
    err_d    = err_q | (inport_ack_i & empty) | (inport_accept_i & ~fwd);
  end

`ifdef SDRAM_ARB_RR_EN
  always_comb begin
    last_d = last_q;
    if (accept) last_d = winner;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= UNLOCKED;
      owner_q  <= 1'b0;
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      tags_q   <= tags_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

`ifdef SDRAM_ARB_RR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: a scoreboard of expected (master, data) pairs
// is filled as requests are accepted and drained as the bench's controller model acks.
module tb_sdram_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  m0_wr_i, m1_wr_i;
  logic        m0_rd_i, m1_rd_i;
  logic [31:0] m0_addr_i, m1_addr_i, m0_write_data_i, m1_write_data_i;
  logic        m0_accept_o, m1_accept_o, m0_ack_o, m1_ack_o;
  logic [31:0] m0_read_data_o, m1_read_data_o;
  logic [3:0]  inport_wr_o;
  logic        inport_rd_o;
  logic [31:0] inport_addr_o, inport_write_data_o;
  logic        inport_accept_i, inport_ack_i;
  logic [31:0] inport_read_data_i;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  logic model_last;

  always #5 clk_i = ~clk_i;

  sdram_port_arbiter #(.OUTSTANDING(4)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .m0_wr_i             (m0_wr_i),
    .m0_rd_i             (m0_rd_i),
    .m0_addr_i           (m0_addr_i),
    .m0_write_data_i     (m0_write_data_i),
    .m0_accept_o         (m0_accept_o),
    .m0_ack_o            (m0_ack_o),
    .m0_read_data_o      (m0_read_data_o),
    .m1_wr_i             (m1_wr_i),
    .m1_rd_i             (m1_rd_i),
    .m1_addr_i           (m1_addr_i),
    .m1_write_data_i     (m1_write_data_i),
    .m1_accept_o         (m1_accept_o),
    .m1_ack_o            (m1_ack_o),
    .m1_read_data_o      (m1_read_data_o),
    .inport_wr_o         (inport_wr_o),
    .inport_rd_o         (inport_rd_o),
    .inport_addr_o       (inport_addr_o),
    .inport_write_data_o (inport_write_data_o),
    .inport_accept_i     (inport_accept_i),
    .inport_ack_i        (inport_ack_i),
    .inport_read_data_i  (inport_read_data_i),
    .err_o               (err_o)
  );

  function automatic logic exp_winner(input logic r0, input logic r1);
    if (r0 && r1) begin
`ifdef SDRAM_ARB_RR_EN
      return ~model_last;
`else
      return 1'b0;
`endif
    end
    return r1;
  endfunction

  task automatic clr_inputs;
    m0_wr_i = '0; m1_wr_i = '0; m0_rd_i = 1'b0; m1_rd_i = 1'b0;
    m0_addr_i = '0; m1_addr_i = '0; m0_write_data_i = '0; m1_write_data_i = '0;
    inport_accept_i = 1'b0; inport_ack_i = 1'b0; inport_read_data_i = '0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    clr_inputs();
    @(negedge clk_i);
    m0_rd_i = 1'b1; m0_addr_i = 32'h0000_0040; m1_wr_i = 4'hF; m1_addr_i = 32'h0000_0080;
    inport_accept_i = 1'b1; inport_read_data_i = 32'h1234_5678;
    #1;
    checks++;
    if ({inport_rd_o, inport_wr_o, inport_addr_o, inport_write_data_o} !== '0) begin
      failures++;
      $display("FAIL reset_inport: got rd=%0b wr=%h addr=%h wd=%h want all 0",
               inport_rd_o, inport_wr_o, inport_addr_o, inport_write_data_o);
    end
    checks++;
    if ({m0_accept_o, m1_accept_o, m0_ack_o, m1_ack_o, err_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got acc=%b%b ack=%b%b err=%b want 0", m0_accept_o, m1_accept_o,
               m0_ack_o, m1_ack_o, err_o);
    end
    checks++;
    if (m0_read_data_o !== 32'h1234_5678 || m1_read_data_o !== 32'h1234_5678) begin
      failures++;
      $display("FAIL reset_rdata: got %h/%h want 12345678", m0_read_data_o, m1_read_data_o);
    end
    clr_inputs();
    rst_i = 1'b0;
    model_last = 1'b1;
    sb.delete();
  endtask

  task automatic test_single_read;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      m0_rd_i = 1'b1; m0_addr_i = 32'h0000_1000;
      inport_accept_i = (i == 3);
      #1;
      checks++;
      if (inport_rd_o !== 1'b1 || inport_addr_o !== 32'h0000_1000) begin
        failures++;
        $display("FAIL single_fwd[%0d]: got rd=%0b addr=%h want 1/00001000", i, inport_rd_o, inport_addr_o);
      end
      checks++;
      if (m0_accept_o !== (i == 3)) begin
        failures++;
        $display("FAIL single_accept[%0d]: got %0b want %0b", i, m0_accept_o, (i == 3));
      end
      if (i == 3) begin
        sb.push_back('{id: 1'b0, data: 32'hDEAD_BEEF});
        model_last = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      clr_inputs();
      #1;
      checks++;
      if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
        failures++;
        $display("FAIL single_noack[%0d]: got %b%b want 00", i, m0_ack_o, m1_ack_o);
      end
    end
    @(negedge clk_i);
    e = sb.pop_front();
    inport_ack_i = 1'b1; inport_read_data_i = e.data;
    #1;
    checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b10 || m0_read_data_o !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL single_ack: got ack=%b%b data=%h want 10/deadbeef", m0_ack_o, m1_ack_o, m0_read_data_o);
    end
    @(negedge clk_i);
    inport_ack_i = 1'b0;
    #1;
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL single_err: got %0b want 0", err_o);
    end
  endtask

  task automatic test_tie;
    exp_t e;
    logic w, have_ack;
    logic [31:0] waddr;
    int n0 = 0, n1 = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      inport_ack_i = 1'b0;
      have_ack = 1'b0;
      if (i < 8) begin
        m0_rd_i = 1'b1; m1_rd_i = 1'b1;
        m0_addr_i = 32'h0000_0100 + n0; m1_addr_i = 32'h0000_0200 + n1;
        inport_accept_i = 1'b1;
      end else begin
        clr_inputs();
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        have_ack = 1'b1;
        inport_ack_i = 1'b1; inport_read_data_i = e.data;
      end
      w = exp_winner(1'b1, 1'b1);
      waddr = w ? m1_addr_i : m0_addr_i;
      #1;
      if (i < 8) begin
        checks++;
        if ({m0_accept_o, m1_accept_o} !== {~w, w} || inport_addr_o !== waddr) begin
          failures++;
          $display("FAIL tie_grant[%0d]: got acc=%b%b addr=%h want acc=%b%b addr=%h", i,
                   m0_accept_o, m1_accept_o, inport_addr_o, ~w, w, waddr);
        end
        sb.push_back('{id: w, data: 32'hC000_0000 | waddr});
        model_last = w;
        if (w) n1++; else n0++;
      end
      if (have_ack) begin
        checks++;
        if ({m0_ack_o, m1_ack_o} !== {~e.id, e.id} || m0_read_data_o !== e.data) begin
          failures++;
          $display("FAIL tie_ack[%0d]: got ack=%b%b data=%h want ack=%b%b data=%h", i,
                   m0_ack_o, m1_ack_o, m0_read_data_o, ~e.id, e.id, e.data);
        end
      end
    end
    @(negedge clk_i);
    clr_inputs();
  endtask

  task automatic test_lock_hold;
    exp_t e;
    @(negedge clk_i);
    m1_rd_i = 1'b1; m1_addr_i = 32'h2222_0000;
    #1;
    checks++;
    if (inport_addr_o !== 32'h2222_0000 || m1_accept_o !== 1'b0) begin
      failures++;
      $display("FAIL lock_first: got addr=%h acc=%0b want 22220000/0", inport_addr_o, m1_accept_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      m0_rd_i = 1'b1; m0_addr_i = 32'h1111_0000;
      #1;
      checks++;
      if (inport_addr_o !== 32'h2222_0000 || inport_rd_o !== 1'b1) begin
        failures++;
        $display("FAIL lock_hold[%0d]: got addr=%h rd=%0b want 22220000/1", i, inport_addr_o, inport_rd_o);
      end
    end
    @(negedge clk_i);
    inport_accept_i = 1'b1;
    #1;
    checks++;
    if ({m0_accept_o, m1_accept_o} !== 2'b01) begin
      failures++;
      $display("FAIL lock_m1_accept: got %b%b want 01", m0_accept_o, m1_accept_o);
    end
    sb.push_back('{id: 1'b1, data: 32'h2222_0000});
    model_last = 1'b1;
    @(negedge clk_i);
    m1_addr_i = 32'h2222_0004;
    #1;
    checks++;
    if ({m0_accept_o, m1_accept_o} !== 2'b10 || inport_addr_o !== 32'h1111_0000) begin
      failures++;
      $display("FAIL lock_m0_next: got acc=%b%b addr=%h want 10/11110000", m0_accept_o, m1_accept_o, inport_addr_o);
    end
    sb.push_back('{id: 1'b0, data: 32'h1111_0000});
    model_last = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      clr_inputs();
      e = sb.pop_front();
      inport_ack_i = 1'b1; inport_read_data_i = e.data;
      #1;
      checks++;
      if ({m0_ack_o, m1_ack_o} !== {~e.id, e.id} || m1_read_data_o !== e.data) begin
        failures++;
        $display("FAIL lock_ack[%0d]: got ack=%b%b data=%h want ack=%b%b data=%h", i,
                 m0_ack_o, m1_ack_o, m1_read_data_o, ~e.id, e.id, e.data);
      end
    end
    @(negedge clk_i);
    clr_inputs();
  endtask

  task automatic test_fifo_full;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      m0_rd_i = 1'b1; m0_addr_i = 32'h0000_3000 + 32'(4 * i); inport_accept_i = 1'b1;
      #1;
      checks++;
      if (m0_accept_o !== 1'b1) begin
        failures++;
        $display("FAIL full_fill[%0d]: got accept=%0b want 1", i, m0_accept_o);
      end
      sb.push_back('{id: 1'b0, data: 32'h5000_0000 + 32'(i)});
      model_last = 1'b0;
    end
    @(negedge clk_i);
    m0_addr_i = 32'h0000_3010; inport_accept_i = 1'b0;
    #1;
    checks++;
    if (inport_rd_o !== 1'b0) begin
      failures++;
      $display("FAIL full_block: got rd=%0b want 0", inport_rd_o);
    end
    @(negedge clk_i);
    e = sb.pop_front();
    inport_ack_i = 1'b1; inport_read_data_i = e.data;
    #1;
    checks++;
    if (inport_rd_o !== 1'b0 || m0_ack_o !== 1'b1 || m0_read_data_o !== e.data) begin
      failures++;
      $display("FAIL full_pop_same: got rd=%0b ack=%0b data=%h want 0/1/%h", inport_rd_o, m0_ack_o,
               m0_read_data_o, e.data);
    end
    @(negedge clk_i);
    inport_ack_i = 1'b0; inport_accept_i = 1'b1;
    #1;
    checks++;
    if (inport_rd_o !== 1'b1 || m0_accept_o !== 1'b1) begin
      failures++;
      $display("FAIL full_resume: got rd=%0b acc=%0b want 1/1", inport_rd_o, m0_accept_o);
    end
    sb.push_back('{id: 1'b0, data: 32'h5000_0010});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      clr_inputs();
      e = sb.pop_front();
      inport_ack_i = 1'b1; inport_read_data_i = e.data;
      #1;
      checks++;
      if ({m0_ack_o, m1_ack_o} !== 2'b10 || m0_read_data_o !== e.data) begin
        failures++;
        $display("FAIL full_drain[%0d]: got ack=%b%b data=%h want 10/%h", i, m0_ack_o, m1_ack_o,
                 m0_read_data_o, e.data);
      end
    end
    @(negedge clk_i);
    clr_inputs();
    #1;
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL full_err: got %0b want 0", err_o);
    end
  endtask

  task automatic test_protocol_error;
    @(negedge clk_i);
    clr_inputs();
    inport_ack_i = 1'b1;
    #1;
    checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b00) begin
      failures++;
      $display("FAIL err_noack: got %b%b want 00", m0_ack_o, m1_ack_o);
    end
    @(negedge clk_i);
    inport_ack_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: got %0b want 1", err_o);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL err_reset: got %0b want 0", err_o);
    end
    rst_i = 1'b0;
    model_last = 1'b1;
    sb.delete();
    @(negedge clk_i);
    inport_accept_i = 1'b1;
    #1;
    checks++;
    if ({m0_accept_o, m1_accept_o} !== 2'b00) begin
      failures++;
      $display("FAIL err_stray_acc: got %b%b want 00", m0_accept_o, m1_accept_o);
    end
    @(negedge clk_i);
    inport_accept_i = 1'b0;
    #1;
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL err_stray_flag: got %0b want 1", err_o);
    end
    rst_i = 1'b1;
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_async_reset;
    exp_t e;
    logic w;
    logic [31:0] waddr;
    int n0 = 0, n1 = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      m0_rd_i = 1'b1; m0_addr_i = 32'h0000_6000 + 32'(i); inport_accept_i = 1'b1;
      #1;
      sb.push_back('{id: 1'b0, data: 32'h6000_0000});
      model_last = 1'b0;
    end
    @(negedge clk_i);
    m0_addr_i = 32'h0000_6002; inport_accept_i = 1'b0;
    @(negedge clk_i);
    m1_wr_i = 4'hF; m1_addr_i = 32'h0000_7000; m1_write_data_i = 32'hA5A5_0000;
    #1;
    checks++;
    if (inport_addr_o !== 32'h0000_6002 || inport_rd_o !== 1'b1) begin
      failures++;
      $display("FAIL arst_locked: got addr=%h rd=%0b want 00006002/1", inport_addr_o, inport_rd_o);
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (inport_rd_o !== 1'b0 || inport_wr_o !== 4'h0) begin
      failures++;
      $display("FAIL arst_quiet: got rd=%0b wr=%h want 0/0", inport_rd_o, inport_wr_o);
    end
    rst_i = 1'b0;
    sb.delete();
    model_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      m0_rd_i = 1'b1; m0_addr_i = 32'h0000_6100 + n0;
      m1_wr_i = 4'hF; m1_addr_i = 32'h0000_7100 + n1; m1_write_data_i = 32'hA5A5_0000 + n1;
      inport_accept_i = (i < 4);
      w = exp_winner(1'b1, 1'b1);
      waddr = w ? m1_addr_i : m0_addr_i;
      #1;
      if (i < 4) begin
        checks++;
        if ({m0_accept_o, m1_accept_o} !== {~w, w} || inport_addr_o !== waddr ||
            inport_wr_o !== (w ? 4'hF : 4'h0)) begin
          failures++;
          $display("FAIL arst_grant[%0d]: got acc=%b%b addr=%h wr=%h want acc=%b%b addr=%h", i,
                   m0_accept_o, m1_accept_o, inport_addr_o, inport_wr_o, ~w, w, waddr);
        end
        sb.push_back('{id: w, data: 32'hE000_0000 | waddr});
        model_last = w;
        if (w) n1++; else n0++;
      end else begin
        checks++;
        if (inport_rd_o !== 1'b0 || inport_wr_o !== 4'h0) begin
          failures++;
          $display("FAIL arst_full: got rd=%0b wr=%h want 0/0", inport_rd_o, inport_wr_o);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      clr_inputs();
      e = sb.pop_front();
      inport_ack_i = 1'b1; inport_read_data_i = e.data;
      #1;
      checks++;
      if ({m0_ack_o, m1_ack_o} !== {~e.id, e.id} || m1_read_data_o !== e.data) begin
        failures++;
        $display("FAIL arst_ack[%0d]: got ack=%b%b data=%h want ack=%b%b data=%h", i,
                 m0_ack_o, m1_ack_o, m1_read_data_o, ~e.id, e.id, e.data);
      end
    end
    @(negedge clk_i);
    clr_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_lock_hold();
    test_fifo_full();
    test_protocol_error();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
